// File: rtl/leiwand_rv32_uart_tx_pkg.sv
// Shared constants for the leiwand_rv32 UART transmitter: register offsets,
// STATUS bit positions and serializer state encoding.
package leiwand_rv32_uart_tx_pkg;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_EMPTY     = 2;
    localparam int STATUS_OVERFLOW  = 3;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int BAUD_W = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A divisor of zero would stall the bit timer, so it behaves as one.
    function automatic logic [BAUD_W-1:0] eff_div(input logic [BAUD_W-1:0] div);
        return (div == '0) ? BAUD_W'(1) : div;
    endfunction

endpackage

// File: rtl/leiwand_rv32_sync_fifo.sv
// Synchronous FIFO with combinational read port; pointers carry an extra
// wrap bit so full and empty are distinguishable without a separate counter.
module leiwand_rv32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    // Fullness is judged before any same-cycle pop frees a slot.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/leiwand_rv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's valid/ready bus:
// TXDATA pushes into a FIFO, a serializer FSM shifts frames out on o_tx.
module leiwand_rv32_uart_tx
    import leiwand_rv32_uart_tx_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int FIFO_DEPTH       = 8,
    parameter int DEFAULT_BAUD_DIV = 434
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN/8-1:0] i_wen,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_tx
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        offset;
    logic              accept;
    logic              is_write;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow_q;
    logic              ovf_clear;
    logic              baud_we_lo;
    logic              baud_we_hi;
    logic [BAUD_W-1:0] baud_div_q;
    logic [XLEN-1:0]   rd_word;

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt_q;
    logic [BAUD_W-1:0] period_q;
    logic [BAUD_W-1:0] latched_div_q;
    logic              load_frame;
    logic              bit_end;
    logic              busy;

    logic unused_bits;
    assign unused_bits = ^{i_addr[XLEN-1:4], i_addr[1:0], i_wdata[XLEN-1:16], i_wen[XLEN/8-1:2]};

    // A held request is not re-accepted while its acknowledge is showing.
    assign accept     = i_valid && !o_ready;
    assign is_write   = |i_wen;
    assign offset     = i_addr[3:2];
    assign fifo_push  = accept && (offset == UART_TXDATA) && i_wen[0];
    assign ovf_clear  = accept && (offset == UART_STATUS) && i_wen[0] && i_wdata[STATUS_OVERFLOW];
    assign baud_we_lo = accept && (offset == UART_BAUDDIV) && i_wen[0];
    assign baud_we_hi = accept && (offset == UART_BAUDDIV) && i_wen[1];
    assign busy       = (state_q != TX_IDLE);

    leiwand_rv32_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (i_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rd_word = '0;
        case (offset)
            UART_STATUS: begin
                rd_word[STATUS_BUSY]                  = busy;
                rd_word[STATUS_FULL]                  = fifo_full;
                rd_word[STATUS_EMPTY]                 = fifo_empty;
                rd_word[STATUS_OVERFLOW]              = overflow_q;
                rd_word[STATUS_COUNT_LSB +: CNT_W]    = fifo_count;
            end
            UART_BAUDDIV: rd_word[BAUD_W-1:0] = baud_div_q;
            default:      rd_word = '0;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ready    <= 1'b0;
            o_rdata    <= '0;
            overflow_q <= 1'b0;
            baud_div_q <= BAUD_W'(DEFAULT_BAUD_DIV);
        end else begin
            o_ready <= accept;
            o_rdata <= (accept && !is_write) ? rd_word : '0;
            if (fifo_push && fifo_full) overflow_q <= 1'b1;
            else if (ovf_clear)         overflow_q <= 1'b0;
            if (baud_we_lo) baud_div_q[7:0]  <= i_wdata[7:0];
            if (baud_we_hi) baud_div_q[15:8] <= i_wdata[15:8];
        end
    end

    assign bit_end = (period_q == '0);

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;
        o_tx       = 1'b1;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_frame = 1'b1;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                o_tx = 1'b0;
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                o_tx = shift_q[0];
                if (bit_end && (bit_cnt_q == 3'd7)) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load_frame = 1'b1;
                        state_d    = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= TX_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            period_q      <= '0;
            latched_div_q <= BAUD_W'(1);
        end else begin
            state_q <= state_d;
            if (load_frame) begin
                // Divisor is frozen per frame so mid-frame BAUDDIV writes cannot distort it.
                shift_q       <= fifo_dout;
                latched_div_q <= eff_div(baud_div_q);
                period_q      <= eff_div(baud_div_q) - BAUD_W'(1);
                bit_cnt_q     <= '0;
            end else if (state_q != TX_IDLE) begin
                if (bit_end) begin
                    period_q <= latched_div_q - BAUD_W'(1);
                    if (state_q == TX_DATA) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end else begin
                    period_q <= period_q - BAUD_W'(1);
                end
            end
        end
    end

endmodule
